// File: rtl/lsq_issue_arbiter_pkg.sv
// Shared types for the load/store-queue issue arbiter.
//   lsq_arb_state_t : arbiter state (NORMAL / STORE_PRIO / DRAIN; encoding 3 unused)
//   elig_t          : per-cycle eligibility of the load, store and fused heads
//   issue_sel_t     : one-hot issue selection
//   pick()          : state-dependent priority pick
package lsq_issue_arbiter_pkg;

  localparam int DEF_STARVE_LIMIT = 8;
  localparam int DEF_CNT_W        = 4;

  typedef enum logic [1:0] {
    ARB_NORMAL     = 2'd0,
    ARB_STORE_PRIO = 2'd1,
    ARB_DRAIN      = 2'd2,
    ARB_RSVD       = 2'd3
  } lsq_arb_state_t;

  typedef struct packed {
    logic load_ok;
    logic store_ok;
    logic fused_ok;
  } elig_t;

  typedef struct packed {
    logic load;
    logic store;
    logic fused;
  } issue_sel_t;

  // A fused pair always wins: it retires one head from each queue at once.
  // The unused encoding selects as NORMAL while it recovers.
  function automatic issue_sel_t pick(input lsq_arb_state_t st, input elig_t e);
    issue_sel_t s;
    s = '0;
    if (e.fused_ok) begin
      s.fused = 1'b1;
    end else begin
      case (st)
        ARB_STORE_PRIO: begin
          if (e.store_ok)     s.store = 1'b1;
          else if (e.load_ok) s.load  = 1'b1;
        end
        ARB_DRAIN: begin
          s.store = e.store_ok;
        end
        default: begin
          if (e.load_ok)       s.load  = 1'b1;
          else if (e.store_ok) s.store = 1'b1;
        end
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/lsq_issue_arbiter_if.sv
// Handshake bundle between the load/store queues, the LSU and the issue arbiter.
//   queue status : lq_valid/lq_conflict/lq_paired, sq_valid/sq_paired/sq_full/sq_empty
//   control      : memq_flush, fence_req (level, held until fence_done), issue_ready
//   results      : issue_valid, sel_load/sel_store/sel_fused, lq_pop/sq_pop,
//                  fence_done, arb_state
// modport master : queue/LSU side (drives status, observes results)
// modport slave  : arbiter side
interface lsq_issue_arbiter_if;

  logic       memq_flush;
  logic       lq_valid;
  logic       lq_conflict;
  logic       lq_paired;
  logic       sq_valid;
  logic       sq_paired;
  logic       sq_full;
  logic       sq_empty;
  logic       fence_req;
  logic       issue_ready;

  logic       issue_valid;
  logic       sel_load;
  logic       sel_store;
  logic       sel_fused;
  logic       lq_pop;
  logic       sq_pop;
  logic       fence_done;
  logic [1:0] arb_state;

  modport master (
    output memq_flush, lq_valid, lq_conflict, lq_paired,
           sq_valid, sq_paired, sq_full, sq_empty, fence_req, issue_ready,
    input  issue_valid, sel_load, sel_store, sel_fused,
           lq_pop, sq_pop, fence_done, arb_state
  );

  modport slave (
    input  memq_flush, lq_valid, lq_conflict, lq_paired,
           sq_valid, sq_paired, sq_full, sq_empty, fence_req, issue_ready,
    output issue_valid, sel_load, sel_store, sel_fused,
           lq_pop, sq_pop, fence_done, arb_state
  );

endinterface

// File: rtl/lsq_issue_arbiter.sv
// Issue arbiter between the load-queue head and the store-queue head.
// Selection is purely combinational from the current state and queue status;
// only the state and the store-starvation counter are registered.
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : lsq_issue_arbiter_if.slave (queue status in, selection/pops/trace out)
// Parameters:
//   STARVE_LIMIT : loads an eligible store may lose to before store priority
//   CNT_W        : starvation counter width, STARVE_LIMIT < 2**CNT_W
module lsq_issue_arbiter
  import lsq_issue_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  lsq_issue_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  lsq_arb_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  elig_t            elig;
  issue_sel_t       sel;
  logic             lq_pop, sq_pop, fence_done;

  always_comb begin
    elig.load_ok  = bus.lq_valid & ~bus.lq_conflict & ~bus.lq_paired;
    elig.store_ok = bus.sq_valid & ~bus.sq_paired;
    elig.fused_ok = bus.lq_valid & bus.lq_paired & bus.sq_valid & bus.sq_paired;
  end

  // State register
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output logic: selection, pops and drain completion
  always_comb begin
    sel        = pick(state_q, elig);
    lq_pop     = bus.issue_ready & (sel.load  | sel.fused);
    sq_pop     = bus.issue_ready & (sel.store | sel.fused);
    // A flush aborts the drain, so completion is never reported under it.
    fence_done = (state_q == ARB_DRAIN) & bus.sq_empty & ~sq_pop & ~bus.memq_flush;
  end

  // Starvation counter: counts loads that beat a ready store, saturating.
  always_comb begin
    // NOTE: default assignment first keeps every comb block free of inferred latches.
    cnt_d = cnt_q;
    if (bus.memq_flush || sq_pop) begin
      cnt_d = '0;
    end else if (elig.store_ok && sel.load && bus.issue_ready && cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic. The starvation check looks at the updated count so the
  // store wins on the very cycle after its LIMIT-th loss.
  always_comb begin
    state_d = state_q;
    if (bus.memq_flush) begin
      state_d = ARB_NORMAL;
    end else if (bus.fence_req && state_q != ARB_DRAIN) begin
      state_d = ARB_DRAIN;
    end else begin
      case (state_q)
        ARB_NORMAL: begin
          if (cnt_d == LIMIT || (bus.sq_full && elig.store_ok)) state_d = ARB_STORE_PRIO;
        end
        ARB_STORE_PRIO: begin
          if (sq_pop) state_d = ARB_NORMAL;
        end
        ARB_DRAIN: begin
          if (bus.sq_empty && !sq_pop) state_d = ARB_NORMAL;
        end
        default: state_d = ARB_NORMAL;
      endcase
    end
  end

  assign bus.issue_valid = sel.load | sel.store | sel.fused;
  assign bus.sel_load    = sel.load;
  assign bus.sel_store   = sel.store;
  assign bus.sel_fused   = sel.fused;
  assign bus.lq_pop      = lq_pop;
  assign bus.sq_pop      = sq_pop;
  assign bus.fence_done  = fence_done;
  assign bus.arb_state   = state_q;

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Self-checking bench for lsq_issue_arbiter. A small cycle model predicts the
// output vector for each driven cycle; the prediction is queued and popped
// when the outputs are sampled. Directed scenarios add hand-derived checks.
module tb_lsq_issue_arbiter;
  import lsq_issue_arbiter_pkg::*;

  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsq_issue_arbiter_if bus ();

  lsq_issue_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int m_state;
  int m_cnt;

  // output vector: {issue_valid, sel_load, sel_store, sel_fused, lq_pop, sq_pop, fence_done, arb_state[1:0]}
  logic [8:0] sb[$];
  logic [8:0] obs;
  logic [8:0] exp_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.issue_valid, bus.sel_load, bus.sel_store, bus.sel_fused,
            bus.lq_pop, bus.sq_pop, bus.fence_done, bus.arb_state};
  endfunction

  function automatic logic [8:0] model_out();
    bit lo, so, fo, l, s, f, lp, sp, fd;
    lo = bus.lq_valid && !bus.lq_conflict && !bus.lq_paired;
    so = bus.sq_valid && !bus.sq_paired;
    fo = bus.lq_valid && bus.lq_paired && bus.sq_valid && bus.sq_paired;
    l = 0; s = 0; f = 0;
    if (fo) f = 1;
    else if (m_state == 1) begin
      if (so) s = 1; else if (lo) l = 1;
    end else if (m_state == 2) begin
      if (so) s = 1;
    end else begin
      if (lo) l = 1; else if (so) s = 1;
    end
    lp = bus.issue_ready && (l || f);
    sp = bus.issue_ready && (s || f);
    fd = (m_state == 2) && bus.sq_empty && !sp && !bus.memq_flush;
    return {l || s || f, l, s, f, lp, sp, fd, 2'(m_state)};
  endfunction

  function automatic void model_update();
    logic [8:0] e;
    bit so, sp, l;
    int nc, ns;
    e  = model_out();
    l  = e[7];
    sp = e[3];
    so = bus.sq_valid && !bus.sq_paired;
    nc = m_cnt;
    ns = m_state;
    if (bus.memq_flush || sp) nc = 0;
    else if (so && l && bus.issue_ready && m_cnt < LIMIT) nc = m_cnt + 1;
    if (bus.memq_flush) ns = 0;
    else if (bus.fence_req && m_state != 2) ns = 2;
    else if (m_state == 0) begin
      if (nc == LIMIT || (bus.sq_full && so)) ns = 1;
    end else if (m_state == 1) begin
      if (sp) ns = 0;
    end else begin
      if (bus.sq_empty && !sp) ns = 0;
    end
    m_cnt   = nc;
    m_state = ns;
  endfunction

  // One clock cycle: inputs are already driven (posedge+1).
  task automatic step(input string tag);
    logic [8:0] e;
    sb.push_back(model_out());
    #2;
    obs      = dut_vec();
    e        = sb.pop_front();
    exp_last = e;
    check(tag, obs, e);
    @(posedge clk);
    if (rst) model_update();
    #1;
  endtask

  task automatic idle();
    bus.memq_flush  = 1'b0;
    bus.lq_valid    = 1'b0;
    bus.lq_conflict = 1'b0;
    bus.lq_paired   = 1'b0;
    bus.sq_valid    = 1'b0;
    bus.sq_paired   = 1'b0;
    bus.sq_full     = 1'b0;
    bus.sq_empty    = 1'b1;
    bus.fence_req   = 1'b0;
    bus.issue_ready = 1'b1;
  endtask

  task automatic flush_clean();
    idle();
    bus.memq_flush = 1'b1;
    step("flush");
    bus.memq_flush = 1'b0;
  endtask

  // Loads and a store both pending; count loads issued before the first store.
  task automatic run_starve(input string tag, output int n_loads, output int first_store,
                            output logic [1:0] st_at_store, output logic [1:0] st_after);
    n_loads = 0; first_store = -1; st_at_store = 2'd3; st_after = 2'd3;
    bus.lq_valid = 1'b1; bus.sq_valid = 1'b1; bus.sq_empty = 1'b0; bus.issue_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(tag);
      if (first_store >= 0 && i == first_store + 1) st_after = obs[1:0];
      if (first_store < 0 && obs[3]) begin
        first_store = i;
        st_at_store = obs[1:0];
      end
      if (first_store < 0 && obs[4]) n_loads++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fs, sq_pops, lq_pops, fd_cnt, fd_cyc, left, held;
    logic [1:0] s0, s1;
    logic done_seen;

    // Reset: NORMAL, selection still follows inputs combinationally.
    rst = 1'b0; m_state = 0; m_cnt = 0;
    idle();
    bus.lq_valid = 1'b1;
    @(posedge clk); #1;
    step("reset_vec");
    check("reset_state", obs[1:0], 0);
    check("reset_sel_load", obs[7], 1);
    check("reset_fence_done", obs[2], 0);
    rst = 1'b1;

    // Starvation: 8 loads, then the store on the 9th cycle in STORE_PRIO.
    flush_clean();
    run_starve("starve", n, fs, s0, s1);
    check("starve_loads", n, 8);
    check("starve_store_cyc", fs, 8);
    check("starve_state_at_store", s0, 1);
    check("starve_state_after", s1, 0);

    // Store queue full: one load, then the store under store priority.
    flush_clean();
    bus.lq_valid = 1'b1; bus.sq_valid = 1'b1; bus.sq_empty = 1'b0; bus.sq_full = 1'b1;
    step("full_c0");
    check("full_c0_load", obs[7], 1);
    step("full_c1");
    check("full_c1_store", obs[6], 1);
    check("full_c1_sq_pop", obs[3], 1);
    check("full_c1_state", obs[1:0], 1);

    // Fence with three stores and a ready load: only stores drain.
    flush_clean();
    left = 3; sq_pops = 0; lq_pops = 0; fd_cnt = 0; fd_cyc = -1; done_seen = 1'b0;
    bus.lq_valid = 1'b1; bus.fence_req = 1'b1; bus.issue_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) bus.issue_ready = 1'b1;
      bus.sq_valid = (left > 0);
      bus.sq_empty = (left == 0);
      step("fence");
      if (exp_last[3]) left--;
      if (!done_seen) begin
        sq_pops += int'(obs[3]);
        lq_pops += int'(obs[4]);
      end
      if (obs[2]) begin
        fd_cnt++;
        fd_cyc = i;
        done_seen = 1'b1;
        bus.fence_req = 1'b0;
      end
      if (i == 5) s0 = obs[1:0];
    end
    check("fence_sq_pops", sq_pops, 3);
    check("fence_lq_pops", lq_pops, 0);
    check("fence_done_cnt", fd_cnt, 1);
    check("fence_done_cyc", fd_cyc, 4);
    check("fence_exit_state", s0, 0);

    // Fence with an already empty store queue.
    flush_clean();
    bus.fence_req = 1'b1;
    step("fence_empty_c0");
    step("fence_empty_c1");
    check("fence_empty_done", obs[2], 1);
    check("fence_empty_state", obs[1:0], 2);
    bus.fence_req = 1'b0;
    step("fence_empty_c2");
    check("fence_empty_back", obs[1:0], 0);

    // Fused pair under store priority pops both queues.
    flush_clean();
    bus.sq_valid = 1'b1; bus.sq_empty = 1'b0; bus.sq_full = 1'b1; bus.issue_ready = 1'b0;
    step("fused_enter");
    bus.lq_valid = 1'b1; bus.lq_paired = 1'b1; bus.sq_paired = 1'b1; bus.issue_ready = 1'b1;
    step("fused_pick");
    check("fused_state", obs[1:0], 1);
    check("fused_sel", obs[5], 1);
    check("fused_pops", {obs[4], obs[3]}, 2'b11);

    // Flush during DRAIN: no fence_done, back to NORMAL, counter cleared.
    flush_clean();
    bus.lq_valid = 1'b1; bus.sq_valid = 1'b1; bus.sq_empty = 1'b0;
    for (int i = 0; i < 3; i++) step("pre_flush_loads");
    bus.fence_req = 1'b1; bus.issue_ready = 1'b0;
    step("flush_drain_c0");
    step("flush_drain_c1");
    check("flush_drain_state", obs[1:0], 2);
    bus.sq_valid = 1'b0; bus.sq_empty = 1'b1; bus.memq_flush = 1'b1;
    step("flush_drain_c2");
    check("flush_no_done", obs[2], 0);
    bus.memq_flush = 1'b0; bus.fence_req = 1'b0; bus.lq_valid = 1'b0;
    step("flush_drain_c3");
    check("flush_back_normal", obs[1:0], 0);
    run_starve("post_flush_starve", n, fs, s0, s1);
    check("flush_cnt_cleared", n, 8);

    // Stall: selection held, no pops, counter frozen.
    flush_clean();
    bus.lq_valid = 1'b1; bus.sq_valid = 1'b1; bus.sq_empty = 1'b0;
    for (int i = 0; i < 3; i++) step("pre_stall_loads");
    bus.issue_ready = 1'b0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      step("stall");
      if (obs[7] && !obs[4] && !obs[3]) held++;
    end
    check("stall_held", held, 5);
    run_starve("post_stall_starve", n, fs, s0, s1);
    check("stall_cnt_kept", n, LIMIT - 3);

    // Reset in the middle of a drain: abort without fence_done.
    flush_clean();
    bus.fence_req = 1'b1; bus.sq_valid = 1'b1; bus.sq_empty = 1'b0; bus.issue_ready = 1'b0;
    step("rd_c0");
    step("rd_c1");
    check("rd_in_drain", obs[1:0], 2);
    rst = 1'b0; m_state = 0; m_cnt = 0;
    bus.fence_req = 1'b0; bus.sq_valid = 1'b0; bus.sq_empty = 1'b1;
    step("rd_reset");
    check("rd_state", obs[1:0], 0);
    check("rd_no_done", obs[2], 0);
    rst = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.memq_flush  = ($urandom_range(0, 15) == 0);
      bus.lq_valid    = ($urandom_range(0, 3) != 0);
      bus.lq_conflict = ($urandom_range(0, 5) == 0);
      bus.lq_paired   = ($urandom_range(0, 4) == 0);
      bus.sq_valid    = ($urandom_range(0, 2) != 0);
      bus.sq_paired   = ($urandom_range(0, 4) == 0);
      bus.sq_full     = ($urandom_range(0, 7) == 0);
      bus.sq_empty    = ($urandom_range(0, 3) == 0);
      bus.fence_req   = ($urandom_range(0, 9) == 0);
      bus.issue_ready = ($urandom_range(0, 4) != 0);
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
